hazard_ctrl: RTL

Stall/flush controller for the 5-stage 16-bit pipeline: it drives the `nop` bubble input of the ID/EX register, and the write enables and flush for the PC and IF/ID registers. It sits beside the decode stage. It compares the instruction in ID against destination fields already latched in ID/EX and EX/MEM, inserts load-use and branch-operand bubbles, squashes the fetch slot on taken branches, and drains the pipe on HLT. It also keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller beside the decode stage: load-use and branch-operand
// bubbles, taken-branch squash, HLT drain, saturating stall/flush counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_SrcReg1,
    input  logic [3:0]       id_SrcReg2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             id_is_br,
    input  logic             id_branch_taken,
    input  logic             id_halt,
    input  logic             idex_RegWrite,
    input  logic             idex_MemtoReg,
    input  logic [3:0]       idex_DstReg,
    input  logic             exmem_RegWrite,
    input  logic             exmem_MemtoReg,
    input  logic [3:0]       exmem_DstReg,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_nop,
    output logic             halt_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           r_state;
    logic [DW-1:0]    r_drain;
    logic             r_halt_done;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;

    logic w_ex_load, w_mem_load, w_ex_nz, w_mem_nz;
    logic w_load_use, w_br_alu, w_br_load, w_hz;

    assign w_ex_load  = idex_RegWrite & idex_MemtoReg;
    assign w_mem_load = exmem_RegWrite & exmem_MemtoReg;
    assign w_ex_nz    = (idex_DstReg != 4'd0);
    assign w_mem_nz   = (exmem_DstReg != 4'd0);

    // R0 is hardwired zero, so a destination of R0 never creates a dependency.
    assign w_load_use = w_ex_load & w_ex_nz &
                        ((id_uses_src1 & (idex_DstReg == id_SrcReg1)) |
                         (id_uses_src2 & (idex_DstReg == id_SrcReg2)));
    assign w_br_alu   = id_is_br & idex_RegWrite & ~idex_MemtoReg & w_ex_nz &
                        (idex_DstReg == id_SrcReg1);
    assign w_br_load  = id_is_br &
                        ((w_ex_load & w_ex_nz & (idex_DstReg == id_SrcReg1)) |
                         (w_mem_load & w_mem_nz & (exmem_DstReg == id_SrcReg1)));
    assign w_hz       = w_load_use | w_br_alu | w_br_load;

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_nop      = 1'b0;
        if (r_state != RUN) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_nop      = 1'b1;
        end else if (w_hz) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_nop      = 1'b1;
        end else if (id_halt) begin
            // HLT moves on into EX; the fetch slot behind it is squashed.
            pc_write_en = 1'b0;
            ifid_flush  = 1'b1;
        end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain     <= '0;
            r_halt_done <= 1'b0;
            r_stall     <= '0;
            r_flush     <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_hz) begin
                        if (!(&r_stall)) r_stall <= r_stall + 1'b1;
                    end else if (id_halt) begin
                        r_state <= DRAIN;
                        r_drain <= DW'(DRAIN_CYCLES - 1);
                    end else if (id_branch_taken) begin
                        if (!(&r_flush)) r_flush <= r_flush + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain == '0) begin
                        r_state     <= HALTED;
                        r_halt_done <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    assign halt_done    = r_halt_done;
    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;

endmodule
